// File: rtl/reg_bus_sequencer_pkg.sv
// Shared types, defaults and helpers for the register bus sequencer.
package reg_bus_sequencer_pkg;

  localparam int unsigned DEF_NUM_REGS = 8;
  localparam int unsigned DEF_ID_WIDTH = 3;
  localparam int unsigned DEF_NUM_REQ  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_XFER  = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  // A move is legal when it names two distinct, existing registers.
  function automatic logic move_legal(input int unsigned s, input int unsigned d,
                                      input int unsigned num_regs);
    return (s != d) && (s < num_regs) && (d < num_regs);
  endfunction

endpackage

// File: rtl/reg_bus_sequencer_if.sv
// Requester handshake plus register-bank strobes of the bus sequencer.
interface reg_bus_sequencer_if
  import reg_bus_sequencer_pkg::*;
#(
  parameter int unsigned NUM_REQ  = DEF_NUM_REQ,
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned ID_WIDTH = DEF_ID_WIDTH
);

  logic [NUM_REQ-1:0]          req;
  logic [NUM_REQ*ID_WIDTH-1:0] src;
  logic [NUM_REQ*ID_WIDTH-1:0] dst;
  logic [NUM_REQ-1:0]          ack;
  logic [NUM_REQ-1:0]          err;
  logic [NUM_REQ-1:0]          grant;
  logic                        busy;
  logic [NUM_REGS-1:0]         reg_cs;
  logic [NUM_REGS-1:0]         reg_we;
  logic [NUM_REGS-1:0]         reg_oe;

  modport master (
    output req, src, dst,
    input  ack, err, grant, busy, reg_cs, reg_we, reg_oe
  );

  modport slave (
    input  req, src, dst,
    output ack, err, grant, busy, reg_cs, reg_we, reg_oe
  );

endinterface

// File: rtl/reg_bus_sequencer_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after pointer wins.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   pointer,
  output logic [NUM_REQ-1:0] winner
);

  logic [PTR_W:0] idx;
  logic           found;

  // Walk the requesters from pointer, wrapping modulo NUM_REQ.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, pointer} + (PTR_W+1)'(i);
      if (idx >= (PTR_W+1)'(NUM_REQ)) idx = idx - (PTR_W+1)'(NUM_REQ);
      if (en && !found && req[idx[PTR_W-1:0]]) begin
        winner[idx[PTR_W-1:0]] = 1'b1;
        found                  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_bus_sequencer.sv
// Arbitrates register-to-register moves and drives the CS/WE/OE strobe pattern.
module reg_bus_sequencer
  import reg_bus_sequencer_pkg::*;
#(
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned ID_WIDTH = DEF_ID_WIDTH,
  parameter int unsigned NUM_REQ  = DEF_NUM_REQ
) (
  input logic                clk,
  input logic                reset,
  reg_bus_sequencer_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  seq_state_e          state;
  logic [PTR_W-1:0]    ptr;
  logic [ID_WIDTH-1:0] src_q;
  logic [ID_WIDTH-1:0] dst_q;

  logic [NUM_REQ-1:0]  win;
  logic [PTR_W-1:0]    win_idx;
  logic [PTR_W:0]      win_inc;
  logic [PTR_W-1:0]    ptr_next;
  logic [ID_WIDTH-1:0] win_src;
  logic [ID_WIDTH-1:0] win_dst;
  logic                win_legal;
  logic [NUM_REGS-1:0] win_src_oh;
  logic [NUM_REGS-1:0] src_oh;
  logic [NUM_REGS-1:0] dst_oh;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .en      (state == ST_IDLE),
    .req     (bus.req),
    .pointer (ptr),
    .winner  (win)
  );

  // Winner index, its ids, legality and the rotated pointer.
  always_comb begin
    win_idx = '0;
    win_src = '0;
    win_dst = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (win[k]) begin
        win_idx = PTR_W'(k);
        win_src = bus.src[k*ID_WIDTH +: ID_WIDTH];
        win_dst = bus.dst[k*ID_WIDTH +: ID_WIDTH];
      end
    end
    win_inc   = {1'b0, win_idx} + (PTR_W+1)'(1);
    ptr_next  = (win_inc >= (PTR_W+1)'(NUM_REQ)) ? '0 : win_inc[PTR_W-1:0];
    win_legal = move_legal(32'(win_src), 32'(win_dst), NUM_REGS);
  end

  // Register id to one-hot strobe decoders.
  always_comb begin
    win_src_oh = '0;
    src_oh     = '0;
    dst_oh     = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      win_src_oh[r] = (32'(win_src) == r);
      src_oh[r]     = (32'(src_q) == r);
      dst_oh[r]     = (32'(dst_q) == r);
    end
  end

  // Move sequencer: state, pointer, latched ids and all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      bus.ack    <= '0;
      bus.err    <= '0;
      bus.grant  <= '0;
      bus.busy   <= 1'b0;
      bus.reg_cs <= '0;
      bus.reg_we <= '0;
      bus.reg_oe <= '0;
    end else begin
      bus.ack <= '0;
      bus.err <= '0;
      case (state)
        ST_IDLE: begin
          if (|win) begin
            src_q     <= win_src;
            dst_q     <= win_dst;
            bus.grant <= win;
            ptr       <= ptr_next;
            bus.busy  <= 1'b1;
            if (win_legal) begin
              state      <= ST_SETUP;
              bus.reg_cs <= win_src_oh;
              bus.reg_oe <= win_src_oh;
            end else begin
              // Rejected moves skip the bus entirely and report at once.
              state   <= ST_DONE;
              bus.ack <= win;
              bus.err <= win;
            end
          end
        end
        ST_SETUP: begin
          state      <= ST_XFER;
          bus.reg_cs <= src_oh | dst_oh;
          bus.reg_oe <= src_oh;
          bus.reg_we <= dst_oh;
        end
        ST_XFER: begin
          state      <= ST_DONE;
          bus.reg_cs <= '0;
          bus.reg_oe <= '0;
          bus.reg_we <= '0;
          bus.ack    <= bus.grant;
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          bus.grant <= '0;
          bus.busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bus_sequencer.sv
// Scoreboard bench for reg_bus_sequencer with a transaction-timeline reference model.
module tb_reg_bus_sequencer;

  localparam int unsigned NR = 2;
  localparam int unsigned NG = 8;
  localparam int unsigned IW = 3;

  typedef struct {
    int unsigned rq;
    bit          er;
    logic [7:0]  val;
    int unsigned dst;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;

  reg_bus_sequencer_if #(.NUM_REQ(NR), .NUM_REGS(NG), .ID_WIDTH(IW)) bus ();
  reg_bus_sequencer_if #(.NUM_REQ(NR), .NUM_REGS(6),  .ID_WIDTH(IW)) bus2 ();

  reg_bus_sequencer #(.NUM_REGS(NG), .ID_WIDTH(IW), .NUM_REQ(NR)) dut (
    .clk(clk), .reset(rst_n), .bus(bus)
  );
  reg_bus_sequencer #(.NUM_REGS(6), .ID_WIDTH(IW), .NUM_REQ(NR)) dut6 (
    .clk(clk), .reset(rst_n), .bus(bus2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Register bank as seen through the DUT strobes, and the reference contents.
  logic [7:0] bank_dut [NG];
  logic [7:0] ref_bank [NG];

  // Reference model state and per-cycle expectations.
  bit          m_active;
  int unsigned m_t0, m_len, m_ptr, m_w, m_s, m_d;
  bit          m_ill;
  logic [NG-1:0] exp_cs, exp_we, exp_oe;
  logic [NR-1:0] exp_ack, exp_err, exp_grant;
  logic          exp_busy;
  exp_t          sb[$];

  // A granted move occupies m_len cycles (3 legal, 1 rejected) plus one idle cycle.
  always @(posedge clk) begin
    int unsigned k;
    cyc++;
    exp_cs = '0; exp_we = '0; exp_oe = '0;
    exp_ack = '0; exp_err = '0; exp_grant = '0; exp_busy = 1'b0;
    if (!rst_n) begin
      m_active = 0;
      m_ptr    = 0;
      sb.delete();
    end else begin
      if (m_active && (cyc - m_t0 >= m_len + 1)) m_active = 0;
      if (!m_active && bus.req != '0) begin
        for (int i = NR - 1; i >= 0; i--)
          if (bus.req[(m_ptr + i) % NR]) m_w = (m_ptr + i) % NR;
        m_s      = bus.src[m_w*IW +: IW];
        m_d      = bus.dst[m_w*IW +: IW];
        m_ill    = (m_s == m_d) || (m_s >= NG) || (m_d >= NG);
        m_len    = m_ill ? 1 : 3;
        m_t0     = cyc;
        m_ptr    = (m_w + 1) % NR;
        m_active = 1;
        sb.push_back('{rq: m_w, er: m_ill, val: m_ill ? 8'h00 : ref_bank[m_s], dst: m_d});
      end
      k = cyc - m_t0;
      if (m_active && k < m_len) begin
        exp_busy  = 1'b1;
        exp_grant = NR'(1) << m_w;
        if (k == m_len - 1) begin
          exp_ack = NR'(1) << m_w;
          exp_err = m_ill ? exp_ack : '0;
        end else if (k == 0) begin
          exp_cs = NG'(1) << m_s;
          exp_oe = NG'(1) << m_s;
        end else begin
          exp_cs = (NG'(1) << m_s) | (NG'(1) << m_d);
          exp_oe = NG'(1) << m_s;
          exp_we = NG'(1) << m_d;
        end
      end
    end
  end

  // Monitor: cycle-level compare, invariants, bank capture and scoreboard pop on ack.
  always @(negedge clk) begin
    int unsigned wi, ri;
    exp_t e;
    if (rst_n) begin
      check("ack",    32'(bus.ack),    32'(exp_ack));
      check("err",    32'(bus.err),    32'(exp_err));
      check("grant",  32'(bus.grant),  32'(exp_grant));
      check("busy",   32'(bus.busy),   32'(exp_busy));
      check("reg_cs", 32'(bus.reg_cs), 32'(exp_cs));
      check("reg_oe", 32'(bus.reg_oe), 32'(exp_oe));
      check("reg_we", 32'(bus.reg_we), 32'(exp_we));
      check("inv_oe_onehot0",    32'($countones(bus.reg_oe) <= 1), 32'd1);
      check("inv_we_oe_overlap", 32'(bus.reg_we & bus.reg_oe), 32'd0);
      check("inv_we_onehot0",    32'($countones(bus.reg_we) <= 1), 32'd1);
      check("inv_grant_onehot0", 32'($countones(bus.grant) <= 1), 32'd1);
      if (bus.reg_we != '0 && bus.reg_oe != '0) begin
        wi = 0; ri = 0;
        for (int i = 0; i < NG; i++) begin
          if (bus.reg_we[i]) wi = i;
          if (bus.reg_oe[i]) ri = i;
        end
        bank_dut[wi] = bank_dut[ri];
      end
      if (bus.ack != '0) begin
        if (sb.size() == 0) begin
          check("unexpected_ack", 32'(bus.ack), 32'd0);
        end else begin
          e = sb.pop_front();
          check("sb_ack_owner", 32'(bus.ack), 32'(NR'(1) << e.rq));
          check("sb_err", 32'(bus.err), e.er ? 32'(NR'(1) << e.rq) : 32'd0);
          if (!e.er) begin
            check("sb_dst_value", 32'(bank_dut[e.dst]), 32'(e.val));
            ref_bank[e.dst] = e.val;
          end
        end
      end
    end
  end

  task automatic set_ids(input int k, input int s, input int d);
    bus.src[k*IW +: IW] = IW'(s);
    bus.dst[k*IW +: IW] = IW'(d);
  endtask

  task automatic wait_any_ack(input int budget, output logic [NR-1:0] a);
    a = '0;
    for (int i = 0; i < budget && a == '0; i++) begin
      @(negedge clk);
      a = bus.ack;
    end
    if (a == '0) check("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    bus.req = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [NR-1:0] a;
    int unsigned   last;
    int            gap[NR], age[NR];
    bit            act[NR], dropped[NR];
    int            s, d;

    rst_n = 1'b0;
    bus.req = '0;  bus.src = '0;  bus.dst = '0;
    bus2.req = '0; bus2.src = '0; bus2.dst = '0;
    for (int i = 0; i < NG; i++) begin
      bank_dut[i] = 8'h10 + 8'(i);
      ref_bank[i] = 8'h10 + 8'(i);
    end
    bank_dut[2] = 8'hA5;
    ref_bank[2] = 8'hA5;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_outputs", 32'({bus.ack, bus.err, bus.grant, bus.busy}), 32'd0);
    check("rst_strobes", 32'(bus.reg_cs | bus.reg_we | bus.reg_oe), 32'd0);
    check("rst6_outputs", 32'({bus2.ack, bus2.busy, bus2.reg_cs, bus2.reg_oe}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(bus.busy), 32'd0);

    // Basic move 2 -> 5.
    bus.req[0] = 1'b1; set_ids(0, 2, 5);
    @(negedge clk);
    check("basic_c1_oe", 32'(bus.reg_oe), 32'h04);
    check("basic_c1_cs", 32'(bus.reg_cs), 32'h04);
    @(negedge clk);
    check("basic_c2_cs", 32'(bus.reg_cs), 32'h24);
    check("basic_c2_we", 32'(bus.reg_we), 32'h20);
    check("basic_c2_oe", 32'(bus.reg_oe), 32'h04);
    @(negedge clk);
    check("basic_c3_ack", 32'(bus.ack), 32'h1);
    check("basic_c3_err", 32'(bus.err), 32'h0);
    check("basic_c3_strobes", 32'(bus.reg_cs | bus.reg_we | bus.reg_oe), 32'h0);
    check("basic_reg5", 32'(bank_dut[5]), 32'hA5);
    bus.req[0] = 1'b0;

    // Req dropped in SETUP: move 1 -> 6 still completes.
    @(negedge clk);
    bus.req[0] = 1'b1; set_ids(0, 1, 6);
    @(negedge clk);
    check("drop_grant", 32'(bus.grant), 32'h1);
    bus.req[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("drop_ack", 32'(bus.ack), 32'h1);
    check("drop_reg6", 32'(bank_dut[6]), 32'h11);

    // Illegal move src == dst: ack and err one cycle after sampling, no strobes.
    @(negedge clk);
    bus.req[0] = 1'b1; set_ids(0, 3, 3);
    @(negedge clk);
    check("ill_ack", 32'(bus.ack), 32'h1);
    check("ill_err", 32'(bus.err), 32'h1);
    check("ill_strobes", 32'(bus.reg_cs | bus.reg_we | bus.reg_oe), 32'h0);
    bus.req[0] = 1'b0;
    @(negedge clk);
    check("ill_idle_busy", 32'(bus.busy), 32'h0);

    // Contention from reset: grants alternate 0,1,0,1 with acks 4 cycles apart.
    do_reset();
    bus.req = 2'b11; set_ids(0, 0, 1); set_ids(1, 2, 3);
    last = 0;
    for (int n = 0; n < 4; n++) begin
      wait_any_ack(12, a);
      check("rr_order", 32'(a), (n % 2 == 0) ? 32'h1 : 32'h2);
      if (n > 0) check("rr_spacing", cyc - last, 32'd4);
      last = cyc;
      if (a[0]) set_ids(0, n + 4, n + 1);
      if (a[1]) set_ids(1, n + 1, n + 5);
    end
    bus.req = '0;
    repeat (2) @(negedge clk);

    // Reset mid-XFER: outputs drop at once, move is lost, pointer back to 0.
    @(negedge clk);
    bus.req[1] = 1'b1; set_ids(1, 3, 4);
    @(posedge clk);
    @(posedge clk);
    #2;
    check("midx_we_before", 32'(bus.reg_we), 32'h10);
    rst_n = 1'b0;
    #1;
    check("midx_strobes", 32'(bus.reg_cs | bus.reg_we | bus.reg_oe), 32'h0);
    check("midx_ctrl", 32'({bus.ack, bus.err, bus.grant, bus.busy}), 32'h0);
    bus.req = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("midx_post_busy", 32'(bus.busy), 32'h0);
      check("midx_post_ack", 32'(bus.ack), 32'h0);
    end
    check("midx_reg4", 32'(bank_dut[4]), 32'h14);
    bus.req = 2'b11; set_ids(0, 5, 0); set_ids(1, 6, 7);
    wait_any_ack(12, a);
    check("midx_ptr0", 32'(a), 32'h1);
    bus.req[0] = 1'b0;
    wait_any_ack(12, a);
    check("midx_second", 32'(a), 32'h2);
    bus.req = '0;

    // Random stress.
    for (int k = 0; k < NR; k++) begin
      gap[k] = 0; age[k] = 0; act[k] = 0; dropped[k] = 0;
    end
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      for (int k = 0; k < NR; k++) begin
        if (act[k]) begin
          age[k]++;
          if (bus.ack[k]) begin
            act[k] = 0; bus.req[k] = 1'b0; gap[k] = $urandom_range(0, 3);
          end else if (age[k] > 40) begin
            check("stress_ack_wait", 32'(age[k]), 32'd0);
            act[k] = 0; bus.req[k] = 1'b0;
          end else if (!dropped[k] && bus.grant[k] && $urandom_range(0, 7) == 0) begin
            bus.req[k] = 1'b0; dropped[k] = 1;
          end
        end
        if (!act[k]) begin
          if (gap[k] > 0) gap[k]--;
          else begin
            s = $urandom_range(0, NG - 1);
            d = ($urandom_range(0, 7) == 0) ? s : $urandom_range(0, NG - 1);
            act[k] = 1; age[k] = 0; dropped[k] = 0;
            bus.req[k] = 1'b1; set_ids(k, s, d);
          end
        end
      end
    end
    bus.req = '0;
    repeat (10) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    // Six-register instance: out-of-range ids are rejected, in-range moves run.
    bus2.req[0] = 1'b1; bus2.src[IW-1:0] = 3'd1; bus2.dst[IW-1:0] = 3'd7;
    @(negedge clk);
    check("r6_ill_ack", 32'({bus2.ack, bus2.err}), 32'h5);
    check("r6_ill_strobes", 32'(bus2.reg_cs | bus2.reg_we | bus2.reg_oe), 32'h0);
    bus2.req[0] = 1'b0;
    @(negedge clk);
    bus2.req[0] = 1'b1; bus2.src[IW-1:0] = 3'd6; bus2.dst[IW-1:0] = 3'd0;
    @(negedge clk);
    check("r6_ill2_ack", 32'({bus2.ack, bus2.err}), 32'h5);
    check("r6_ill2_strobes", 32'(bus2.reg_cs | bus2.reg_we | bus2.reg_oe), 32'h0);
    bus2.req[0] = 1'b0;
    @(negedge clk);
    bus2.req[0] = 1'b1; bus2.src[IW-1:0] = 3'd0; bus2.dst[IW-1:0] = 3'd5;
    @(negedge clk);
    check("r6_c1_oe", 32'(bus2.reg_oe), 32'h01);
    @(negedge clk);
    check("r6_c2_we", 32'(bus2.reg_we), 32'h20);
    @(negedge clk);
    check("r6_c3_ack", 32'({bus2.ack, bus2.err}), 32'h4);
    bus2.req[0] = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
